// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the lab storage primitives.
// A zero reset bit is the default reset value, replicated across a register's width.
package d_flip_flop_pkg;

  localparam logic DFF_RESET_BIT = 1'b0;
  localparam int   DFF_MIN_WIDTH = 1;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_bit.sv
// Single-bit rising-edge storage cell with synchronous active-high reset.
module dff_bit
  import d_flip_flop_pkg::*;
#(
  parameter logic RESET_VAL = DFF_RESET_BIT
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = d;
    if (reset) begin
      q_d = RESET_VAL;
    end
  end

  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule : dff_bit

// File: rtl/d_flip_flop.sv
// WIDTH-bit register built from dff_bit cells; each cell takes its own RESET_VAL bit.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < DFF_MIN_WIDTH) begin : g_bad_width
    $fatal(1, "d_flip_flop: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .RESET_VAL(RESET_VAL[i])
    ) u_bit (
      .CLK  (CLK),
      .reset(reset),
      .d    (D[i]),
      .q    (Q[i])
    );
  end

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed and randomized checks of d_flip_flop at WIDTH=1 and WIDTH=8 (RESET_VAL=8'hA5).
module tb_d_flip_flop;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam logic       RV1 = 1'b0;

  logic       CLK = 1'b0;
  logic       rst1, rst8;
  logic [0:0] d1, q1;
  logic [7:0] d8, q8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: what each register should hold after the most recent edge.
  logic       m1;
  logic [7:0] m8;

  always #5 CLK = ~CLK;

  d_flip_flop #(
    .WIDTH(1)
  ) u_dut1 (
    .CLK  (CLK),
    .reset(rst1),
    .D    (d1),
    .Q    (q1)
  );

  d_flip_flop #(
    .WIDTH    (8),
    .RESET_VAL(RV8)
  ) u_dut8 (
    .CLK  (CLK),
    .reset(rst8),
    .D    (d8),
    .Q    (q8)
  );

  task automatic check1(input string tag, input logic exp);
    checks++;
    assert (q1[0] === exp)
    else begin
      errors++;
      $error("FAIL %s: observed Q=%b expected Q=%b", tag, q1[0], exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] exp);
    checks++;
    assert (q8 === exp)
    else begin
      errors++;
      $error("FAIL %s: observed Q=%h expected Q=%h", tag, q8, exp);
    end
  endtask

  // Advance through one rising edge, apply the storage rule to the sampled inputs.
  task automatic clk_edge();
    @(posedge CLK);
    m1 = rst1 ? RV1 : d1[0];
    m8 = rst8 ? RV8 : d8;
    #1;
  endtask

  initial begin
    // t=0
    d1 = 1'b0; rst1 = 1'b0;
    d8 = 8'h00; rst8 = 1'b1;
    clk_edge();                                   // t=6
    check1("first_edge_d0", 1'b0);
    check8("wide_reset_init", 8'hA5);

    #4; d1 = 1'b1; rst8 = 1'b0; d8 = 8'h3C;      // t=10
    clk_edge();                                   // t=16
    check1("capture1", 1'b1);
    check8("wide_capture_3c", 8'h3C);

    #4; d1 = 1'b0;                                // t=20
    #3; check1("hold_before_edge", 1'b1);         // t=23
    clk_edge();                                   // t=26
    check1("capture0", 1'b0);

    #6; rst1 = 1'b1;                              // t=32
    #2; rst1 = 1'b0;                              // t=34
    check1("reset_pulse_no_edge_q0", 1'b0);
    clk_edge();                                   // t=36
    check1("hold0_d0", 1'b0);

    #4; rst1 = 1'b1; d1 = 1'b1;                   // t=40
    rst8 = 1'b1; d8 = 8'h5A;
    #3; check1("pre_reset_edge", 1'b0);           // t=43
    check8("wide_pre_reset_edge", 8'h3C);
    clk_edge();                                   // t=46
    check1("sync_reset_priority", 1'b0);
    check8("wide_sync_reset", 8'hA5);

    #4; rst1 = 1'b0; d1 = 1'b1;                   // t=50
    rst8 = 1'b0; d8 = 8'hFF;
    #3; check1("release_hold", 1'b0);             // t=53
    check8("wide_release_hold", 8'hA5);
    clk_edge();                                   // t=56
    check1("release_load_d1", 1'b1);
    check8("wide_load_ff", 8'hFF);

    #2; d1 = 1'b0; d8 = 8'h00;                    // t=58
    #1; d1 = 1'b1; d8 = 8'h12;
    #1; d1 = 1'b0; d8 = 8'h34;                    // t=60
    check1("hold_toggle", 1'b1);
    check8("wide_hold_toggle", 8'hFF);
    #1; rst1 = 1'b1; rst8 = 1'b1;                 // t=61
    #1; rst1 = 1'b0; rst8 = 1'b0;                 // t=62
    check1("async_pulse_ignored", 1'b1);
    check8("wide_async_pulse_ignored", 8'hFF);
    clk_edge();                                   // t=66
    check1("load_after_toggle", 1'b0);
    check8("wide_load_after_toggle", 8'h34);

    for (int n = 0; n < 80; n++) begin
      @(negedge CLK);
      check1("rand_hold_mid", m1);
      check8("rand_wide_hold_mid", m8);
      d1   = 1'($urandom);
      d8   = 8'($urandom);
      rst1 = ($urandom_range(0, 3) == 0);
      rst8 = ($urandom_range(0, 3) == 0);
      clk_edge();
      check1("rand_edge", m1);
      check8("rand_wide_edge", m8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_d_flip_flop
